// File: rtl/adc_acq_ctrl.sv
`timescale 1ns/1ps
// adc_acq_ctrl
// ------------
// Acquisition sequencer for the dual-channel ADC capture path. It runs in the
// ADC sample clock domain and does the following:
// - enables the capture block;
// - writes packed {ch2,ch1} samples into a circular sample RAM;
// - fills the pre-trigger window, then waits for a level/edge trigger or an
//   auto-trigger timeout;
// - counts the post-trigger samples;
// - publishes the record start address and the trigger address to the reader.
//
// Ports
//   clk, rst_n        sample clock, asynchronous active-low reset
//   start, abort      one-cycle command pulses (arm / return to IDLE)
//   rd_done           one-cycle pulse from the reader: buffer consumed
//   cfg_*             record configuration, latched on arm
//   ch1_data/ch2_data samples from the capture block, qualified by data_valid
//   cap_enable        capture block enable
//   wr_en/wr_addr/wr_data  registered RAM write port
//   trig_addr/start_addr   trigger sample address, first sample of record
//   forced            record was closed by the auto-trigger timeout
//   busy, done        status levels
//   state_o           current FSM state (debug/observability)
//
// Handshake semantics: there is no back-pressure. Every cycle with data_valid
// high while capturing (PRE/ARMED/POST) produces exactly one RAM write.
// wr_en/wr_addr/wr_data for that write appear one cycle later and are valid
// for that single cycle only. start, abort and rd_done are single-cycle pulses
// sampled on the rising clock edge. abort beats every other input.

module adc_acq_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 10,
    parameter int TO_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  rd_done,
    input  logic                  cfg_single,
    input  logic                  cfg_auto,
    input  logic                  cfg_trig_ch,
    input  logic                  cfg_trig_fall,
    input  logic [DATA_W-1:0]     cfg_level,
    input  logic [ADDR_W:0]       cfg_length,
    input  logic [ADDR_W-1:0]     cfg_pretrig,
    input  logic [TO_W-1:0]       cfg_timeout,
    input  logic [DATA_W-1:0]     ch1_data,
    input  logic [DATA_W-1:0]     ch2_data,
    input  logic                  data_valid,
    output logic                  cap_enable,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [2*DATA_W-1:0]   wr_data,
    output logic [ADDR_W-1:0]     trig_addr,
    output logic [ADDR_W-1:0]     start_addr,
    output logic                  forced,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            state_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_W:0]   DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_L   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]   ONE_T   = {{(TO_W-1){1'b0}}, 1'b1};

    // Registers
    logic [2:0]          state_q,     state_d;
    logic                single_q,    single_d;
    logic                auto_q,      auto_d;
    logic                trig_ch_q,   trig_ch_d;
    logic                trig_fall_q, trig_fall_d;
    logic [DATA_W-1:0]   level_q,     level_d;
    logic [ADDR_W:0]     length_q,    length_d;
    logic [ADDR_W-1:0]   pretrig_q,   pretrig_d;
    logic [TO_W-1:0]     timeout_q,   timeout_d;
    logic [ADDR_W:0]     cnt_q,       cnt_d;       // PRE fill count / POST remaining
    logic [TO_W-1:0]     to_cnt_q,    to_cnt_d;
    logic [DATA_W-1:0]   prev_q,      prev_d;
    logic                prev_vld_q,  prev_vld_d;
    logic [ADDR_W-1:0]   ptr_q,       ptr_d;       // address of the next write
    logic                cap_en_q,    cap_en_d;
    logic                wr_en_q,     wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q,   wr_addr_d;
    logic [2*DATA_W-1:0] wr_data_q,   wr_data_d;
    logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
    logic                forced_q,    forced_d;

    // Sanitised configuration as it would be latched this cycle
    logic [ADDR_W:0]     len_san;
    logic [ADDR_W-1:0]   pre_san;

    always_comb begin
        len_san = cfg_length;
        if (cfg_length == '0 || cfg_length > DEPTH_L) begin
            len_san = DEPTH_L;
        end
        pre_san = cfg_pretrig;
        if ({1'b0, cfg_pretrig} >= len_san) begin
            pre_san = ADDR_W'(len_san - ONE_L);
        end
    end

    // Trigger detection on the selected channel
    logic [DATA_W-1:0]   smp;
    logic                rise_hit;
    logic                fall_hit;
    logic                real_hit;
    logic                to_hit;
    logic [ADDR_W:0]     rem_after;

    assign smp       = trig_ch_q ? ch2_data : ch1_data;
    assign rise_hit  = prev_vld_q && (prev_q < level_q) && (smp >= level_q);
    assign fall_hit  = prev_vld_q && (prev_q > level_q) && (smp <= level_q);
    assign real_hit  = trig_fall_q ? fall_hit : rise_hit;
    // to_cnt_q holds the number of ARMED samples already seen, so with a
    // timeout of N the (N+1)-th sample is the forced trigger.
    assign to_hit    = auto_q && (to_cnt_q == timeout_q);
    // Post-trigger samples still to write after the trigger sample itself
    assign rem_after = length_q - {1'b0, pretrig_q} - ONE_L;

    logic                do_write;
    logic                do_latch;
    logic                do_arm;
    logic [ADDR_W-1:0]   pretrig_eff;

    always_comb begin
        state_d      = state_q;
        single_d     = single_q;
        auto_d       = auto_q;
        trig_ch_d    = trig_ch_q;
        trig_fall_d  = trig_fall_q;
        level_d      = level_q;
        length_d     = length_q;
        pretrig_d    = pretrig_q;
        timeout_d    = timeout_q;
        cnt_d        = cnt_q;
        to_cnt_d     = to_cnt_q;
        prev_d       = prev_q;
        prev_vld_d   = prev_vld_q;
        ptr_d        = ptr_q;
        cap_en_d     = cap_en_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        forced_d     = forced_q;
        do_write     = 1'b0;
        do_latch     = 1'b0;
        do_arm       = 1'b0;
        pretrig_eff  = pretrig_q;

        if (abort) begin
            state_d  = S_IDLE;
            cap_en_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        do_latch = 1'b1;
                    end
                end
                S_PRE: begin
                    if (data_valid) begin
                        do_write = 1'b1;
                        cnt_d    = cnt_q + ONE_L;
                        if (cnt_q + ONE_L == {1'b0, pretrig_q}) begin
                            state_d = S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (data_valid) begin
                        do_write   = 1'b1;
                        prev_d     = smp;
                        prev_vld_d = 1'b1;
                        to_cnt_d   = to_cnt_q + ONE_T;
                        if (real_hit || to_hit) begin
                            trig_addr_d  = ptr_q;
                            start_addr_d = ptr_q - pretrig_q;
                            forced_d     = ~real_hit;
                            if (rem_after == '0) begin
                                state_d  = S_DONE;
                                cap_en_d = 1'b0;
                            end else begin
                                cnt_d   = rem_after;
                                state_d = S_POST;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (data_valid) begin
                        do_write = 1'b1;
                        cnt_d    = cnt_q - ONE_L;
                        if (cnt_q == ONE_L) begin
                            state_d  = S_DONE;
                            cap_en_d = 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        do_latch = 1'b1;
                    end else if (!single_q && rd_done) begin
                        do_arm = 1'b1;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    cap_en_d = 1'b0;
                end
            endcase
        end

        if (do_write) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = {ch2_data, ch1_data};
            ptr_d     = ptr_q + ONE_A;
        end

        if (do_latch) begin
            single_d    = cfg_single;
            auto_d      = cfg_auto;
            trig_ch_d   = cfg_trig_ch;
            trig_fall_d = cfg_trig_fall;
            level_d     = cfg_level;
            length_d    = len_san;
            pretrig_d   = pre_san;
            timeout_d   = cfg_timeout;
            pretrig_eff = pre_san;
            do_arm      = 1'b1;
        end

        // Arming keeps the write pointer so consecutive records are contiguous
        if (do_arm) begin
            cnt_d      = '0;
            to_cnt_d   = '0;
            prev_vld_d = 1'b0;
            forced_d   = 1'b0;
            cap_en_d   = 1'b1;
            state_d    = (pretrig_eff == '0) ? S_ARMED : S_PRE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            single_q     <= 1'b0;
            auto_q       <= 1'b0;
            trig_ch_q    <= 1'b0;
            trig_fall_q  <= 1'b0;
            level_q      <= '0;
            length_q     <= '0;
            pretrig_q    <= '0;
            timeout_q    <= '0;
            cnt_q        <= '0;
            to_cnt_q     <= '0;
            prev_q       <= '0;
            prev_vld_q   <= 1'b0;
            ptr_q        <= '0;
            cap_en_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            forced_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            single_q     <= single_d;
            auto_q       <= auto_d;
            trig_ch_q    <= trig_ch_d;
            trig_fall_q  <= trig_fall_d;
            level_q      <= level_d;
            length_q     <= length_d;
            pretrig_q    <= pretrig_d;
            timeout_q    <= timeout_d;
            cnt_q        <= cnt_d;
            to_cnt_q     <= to_cnt_d;
            prev_q       <= prev_d;
            prev_vld_q   <= prev_vld_d;
            ptr_q        <= ptr_d;
            cap_en_q     <= cap_en_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            forced_q     <= forced_d;
        end
    end

    assign cap_enable = cap_en_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign trig_addr  = trig_addr_q;
    assign start_addr = start_addr_q;
    assign forced     = forced_q;
    assign busy       = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
    assign done       = (state_q == S_DONE);
    assign state_o    = state_q;

endmodule
